// File: rtl/delay_cal_pkg.sv
// ============================================================================
// Module   : delay_cal_pkg
// Purpose  : Shared constants and FSM state type for the delay calibrator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_cal_pkg;

    localparam int TAP_W    = 4;
    localparam int NUM_TAPS = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COMPARE = 3'd2,
        ST_STEP    = 3'd3,
        ST_EVAL    = 3'd4,
        ST_SEEK    = 3'd5,
        ST_FIN     = 3'd6
    } cal_state_e;

endpackage

`default_nettype wire

// File: rtl/delay_cal_win_eval.sv
// ============================================================================
// Module   : delay_cal_win_eval
// Purpose  : Combinational search for the longest run of passing taps (no
//            wrap, lowest start wins ties) and the centre tap of that run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_cal_win_eval
    import delay_cal_pkg::*;
(
    input  logic [NUM_TAPS-1:0] map,
    output logic [TAP_W-1:0]    lo,
    output logic [TAP_W:0]      len,
    output logic [TAP_W-1:0]    best_tap,
    output logic                none
);

    logic [TAP_W-1:0] w_run_lo;
    logic [TAP_W:0]   w_run_len;
    logic [TAP_W-1:0] w_half;

    always_comb begin
        lo        = '0;
        len       = '0;
        w_run_lo  = '0;
        w_run_len = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (map[i]) begin
                if (w_run_len == '0) begin
                    w_run_lo = TAP_W'(i);
                end
                w_run_len = w_run_len + 5'd1;
                // Strict compare keeps the earliest run on equal length
                if (w_run_len > len) begin
                    len = w_run_len;
                    lo  = w_run_lo;
                end
            end else begin
                w_run_len = '0;
            end
        end
    end

    assign w_half   = TAP_W'((len - 5'd1) >> 1);
    assign best_tap = lo + w_half;
    assign none     = (len == '0);

endmodule

`default_nettype wire

// File: rtl/delay_cal_ctrl.sv
// ============================================================================
// Module   : delay_cal_ctrl
// Purpose  : Sweeps a 16-tap var_delay15 line, records pass/fail per tap and
//            steps the line to the centre of the widest passing window.
//            Optional macro DELAY_CAL_STATUS_EN adds the pass_map_o port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_cal_ctrl
    import delay_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CMP_CYC    = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_in,
    input  logic             ref_in,
    output logic             inc_pulse,
    output logic [TAP_W-1:0] tap,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [TAP_W-1:0] best_tap
`ifdef DELAY_CAL_STATUS_EN
    ,
    output logic [NUM_TAPS-1:0] pass_map_o
`endif
);

    localparam logic [7:0]       c_settle_last = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       c_cmp_last    = 8'(CMP_CYC - 1);
    localparam logic [TAP_W-1:0] c_last_idx    = TAP_W'(NUM_TAPS - 1);

    cal_state_e          r_state;
    cal_state_e          w_next_state;
    logic [7:0]          r_cnt;
    logic [TAP_W-1:0]    r_idx;
    logic [TAP_W-1:0]    r_tap;
    logic [TAP_W-1:0]    r_base;
    logic [TAP_W-1:0]    r_best;
    logic                r_fail;
    logic                r_mismatch;
    logic                r_seek_gap;
    logic [NUM_TAPS-1:0] r_pass_map;
    logic [TAP_W-1:0]    w_tap_inc;

    logic [TAP_W-1:0]    w_lo;
    logic [TAP_W:0]      w_len;
    logic [TAP_W-1:0]    w_best;
    logic                w_none;
    logic                w_unused_eval;

    delay_cal_win_eval u_win_eval (
        .map      (r_pass_map),
        .lo       (w_lo),
        .len      (w_len),
        .best_tap (w_best),
        .none     (w_none)
    );

    assign w_unused_eval = ^{w_lo, w_len};
    assign w_tap_inc     = r_tap + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        inc_pulse    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_next_state = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (r_cnt == c_cmp_last) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_STEP: begin
                inc_pulse    = 1'b1;
                w_next_state = (r_idx == c_last_idx) ? ST_EVAL : ST_SETTLE;
            end
            ST_EVAL: begin
                // After a full sweep the line is back at base
                if (w_none || (w_best == r_base)) begin
                    w_next_state = ST_FIN;
                end else begin
                    w_next_state = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (!r_seek_gap) begin
                    inc_pulse = 1'b1;
                    if (w_tap_inc == r_best) begin
                        w_next_state = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tap      <= '0;
            r_base     <= '0;
            r_best     <= '0;
            r_fail     <= 1'b0;
            r_mismatch <= 1'b0;
            r_seek_gap <= 1'b0;
            r_pass_map <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base     <= r_tap;
                        r_pass_map <= '0;
                        r_fail     <= 1'b0;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_mismatch <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= (r_cnt == c_settle_last) ? 8'd0 : r_cnt + 8'd1;
                end
                ST_COMPARE: begin
                    if (sample_in != ref_in) begin
                        r_mismatch <= 1'b1;
                    end
                    r_cnt <= (r_cnt == c_cmp_last) ? 8'd0 : r_cnt + 8'd1;
                end
                ST_STEP: begin
                    r_pass_map[r_tap] <= ~r_mismatch;
                    r_mismatch        <= 1'b0;
                    r_tap             <= w_tap_inc;
                    r_idx             <= r_idx + 4'd1;
                    r_cnt             <= '0;
                end
                ST_EVAL: begin
                    if (w_none) begin
                        r_fail <= 1'b1;
                    end else begin
                        r_best <= w_best;
                    end
                    r_seek_gap <= 1'b0;
                end
                ST_SEEK: begin
                    if (!r_seek_gap) begin
                        r_tap      <= w_tap_inc;
                        r_seek_gap <= 1'b1;
                    end else begin
                        r_seek_gap <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DELAY_CAL_STATUS_EN
    logic [NUM_TAPS-1:0] r_pass_map_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_map_last <= '0;
        end else if (r_state == ST_EVAL) begin
            r_pass_map_last <= r_pass_map;
        end
    end

    assign pass_map_o = r_pass_map_last;
`endif

    assign tap      = r_tap;
    assign best_tap = r_best;
    assign fail     = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_delay_cal_ctrl.sv
// ============================================================================
// Module   : tb_delay_cal_ctrl
// Purpose  : Randomised self-checking bench for delay_cal_ctrl with a
//            behavioural var_delay15 model and window reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_cal_ctrl;

    localparam int S     = 4;
    localparam int C     = 32;
    localparam int SLOT  = S + C + 1;
    localparam int SWEEP = 16 * SLOT;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       start     = 1'b0;
    logic       sample_in = 1'b0;
    logic       ref_in    = 1'b0;
    logic       inc_pulse;
    logic [3:0] tap;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] best_tap;
`ifdef DELAY_CAL_STATUS_EN
    logic [15:0] pass_map_o;
`endif

    int         n_tests    = 0;
    int         n_fail     = 0;
    int         pulse_cnt  = 0;
    int         mirror_err = 0;
    int         dbl_err    = 0;
    int         exp_best   = 0;
    bit         armed      = 1'b0;
    bit         prev_inc   = 1'b0;
    logic [3:0] m_tap      = '0;

    delay_cal_ctrl #(
        .SETTLE_CYC (S),
        .CMP_CYC    (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sample_in (sample_in),
        .ref_in    (ref_in),
        .inc_pulse (inc_pulse),
        .tap       (tap),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .best_tap  (best_tap)
`ifdef DELAY_CAL_STATUS_EN
        ,
        .pass_map_o (pass_map_o)
`endif
    );

    always #5 clk = ~clk;

    // Independent var_delay15 model plus pulse bookkeeping
    always @(posedge clk) begin
        if (rst) begin
            m_tap <= '0;
        end else if (inc_pulse) begin
            m_tap     <= m_tap + 4'd1;
            pulse_cnt <= pulse_cnt + 1;
        end
        if (armed && inc_pulse && prev_inc) dbl_err <= dbl_err + 1;
        prev_inc <= armed && inc_pulse && !rst;
    end

    always @(negedge clk) begin
        if (armed && (tap != m_tap)) mirror_err <= mirror_err + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Longest all-ones window, found by trying lengths from 16 down
    function automatic void ref_window(input logic [15:0] m, output int lo, output int len);
        lo  = 0;
        len = 0;
        for (int l = 16; l >= 1 && len == 0; l--) begin
            for (int s = 0; s + l <= 16 && len == 0; s++) begin
                bit ok = 1'b1;
                for (int j = s; j < s + l; j++) if (!m[j]) ok = 1'b0;
                if (ok) begin
                    lo  = s;
                    len = l;
                end
            end
        end
    endfunction

    // Drive one cycle of sweep data; only compare-window mismatches matter
    task automatic drive(input int k, input logic [15:0] pset, inout int fail_off);
        int   off;
        logic r;
        logic mm;
        r  = 1'($urandom);
        mm = 1'b0;
        if (k < SWEEP) begin
            off = k % SLOT;
            if (off == 0) fail_off = S + int'($urandom_range(C - 1, 0));
            if (pset[m_tap]) mm = (off < S || off == S + C) ? 1'($urandom) : 1'b0;
            else             mm = (off == fail_off);
        end else begin
            mm = 1'($urandom);
        end
        ref_in    = r;
        sample_in = r ^ mm;
    endtask

    task automatic run_cal(input string nm, input logic [15:0] pset, input bit hold);
        int  base, lo, len, exp_bst, exp_tap, p, exp_n, lat, k;
        int  pulses0, busy_err, fail_off, swp_tap, swp_pulses, mir0, dbl0;
        bit  none;
        base    = int'(m_tap);
        pulses0 = pulse_cnt;
        mir0    = mirror_err;
        dbl0    = dbl_err;
        ref_window(pset, lo, len);
        none    = (len == 0);
        exp_bst = none ? exp_best : lo + (len - 1) / 2;
        exp_tap = none ? base : exp_bst;
        p       = none ? 0 : (exp_bst - base + 16) % 16;
        exp_n   = SWEEP + 1 + ((p > 0) ? 2 * p - 1 : 0);

        start = 1'b1;
        @(posedge clk); #1;
        k = 0; lat = -1; busy_err = 0; fail_off = S; swp_tap = -1; swp_pulses = -1;
        while (lat < 0 && k <= exp_n + 40) begin
            if (k == SWEEP) begin
                swp_tap    = int'(tap);
                swp_pulses = pulse_cnt - pulses0;
            end
            if (done) begin
                lat = k;
            end else begin
                if (!busy) busy_err++;
                start = hold && (k < SWEEP - 1);
                drive(k, pset, fail_off);
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;

        chk({nm, ":latency"},      lat,                   exp_n);
        chk({nm, ":busy_hi"},      busy_err,              0);
        chk({nm, ":sweep_tap"},    swp_tap,               base);
        chk({nm, ":sweep_pulses"}, swp_pulses,            16);
        chk({nm, ":busy_at_done"}, int'(busy),            0);
        chk({nm, ":fail"},         int'(fail),            int'(none));
        chk({nm, ":best_tap"},     int'(best_tap),        exp_bst);
        chk({nm, ":tap"},          int'(tap),             exp_tap);
        chk({nm, ":pulses"},       pulse_cnt - pulses0,   16 + p);
`ifdef DELAY_CAL_STATUS_EN
        chk({nm, ":pass_map"},     int'(pass_map_o),      int'(pset));
`endif
        @(posedge clk); #1;
        chk({nm, ":done_1cyc"},    int'(done),            0);
        chk({nm, ":idle_busy"},    int'(busy),            0);
        chk({nm, ":tap_mirror"},   mirror_err - mir0,     0);
        chk({nm, ":dbl_pulse"},    dbl_err - dbl0,        0);
        if (!none) exp_best = exp_bst;
    endtask

    task automatic run_reset_mid();
        int fo;
        fo    = S;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            drive(k, 16'hFFFF, fo);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid:tap",       int'(tap),       0);
        chk("rst_mid:busy",      int'(busy),      0);
        chk("rst_mid:inc_pulse", int'(inc_pulse), 0);
        chk("rst_mid:done",      int'(done),      0);
        chk("rst_mid:best_tap",  int'(best_tap),  0);
        rst      = 1'b0;
        exp_best = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] rmap;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        armed = 1'b1;
        chk("reset:tap",       int'(tap),       0);
        chk("reset:busy",      int'(busy),      0);
        chk("reset:done",      int'(done),      0);
        chk("reset:fail",      int'(fail),      0);
        chk("reset:best_tap",  int'(best_tap),  0);
        chk("reset:inc_pulse", int'(inc_pulse), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cal("all_pass",  16'hFFFF, 1'b0);
        run_cal("win3_9",    16'h03F8, 1'b0);
        run_cal("win_long",  16'h1F0E, 1'b0);
        run_cal("win_tie",   16'h0E1C, 1'b0);
        run_cal("to_base5",  16'h0020, 1'b0);
        run_cal("none_pass", 16'h0000, 1'b0);
        run_reset_mid();
        run_cal("after_rst", 16'($urandom), 1'b0);
        run_cal("hold_start", 16'($urandom) | 16'h0100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rmap = 16'($urandom);
            if (i[0]) rmap = rmap & 16'($urandom);
            run_cal("random", rmap, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/delay_cal_ctrl.md
DELAY_CAL_CTRL -- requirements
Module: delay_cal_ctrl

Interface
REQ-001 SETTLE_CYC, default 4, meaning: idle cycles after each tap change before comparison starts; legal range 1..255.
REQ-002 CMP_CYC, default 32, meaning: compare cycles per tap; legal range 1..255.
REQ-003 clk  input  1  meaning: the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  meaning: synchronous, active-high reset.
REQ-005 start  input  1  meaning: one-cycle calibration request; ignored while busy=1.
REQ-006 sample_in  input  1  meaning: delayed signal, i.e. out_sig of the controlled var_delay15.
REQ-007 ref_in  input  1  meaning: expected value of sample_in in the same cycle.
REQ-008 inc_pulse  output  1  meaning: drives var_delay15 inc_pulse; each high cycle advances the tap by one, wrapping 15->0.
REQ-009 tap  output  4  meaning: controller's mirror of the current var_delay15 delay length.
REQ-010 busy  output  1  meaning: high from the cycle after start is accepted until done.
REQ-011 done  output  1  meaning: one-cycle pulse at the end of calibration.
REQ-012 fail  output  1  meaning: set with done when no tap passed; held until the next accepted start.
REQ-013 best_tap  output  4  meaning: selected tap; valid when done=1 and held afterwards.

Function
REQ-014 States SHALL be IDLE, SETTLE, COMPARE, STEP, EVAL, SEEK, FIN.
REQ-015 IDLE: start=1 SHALL latch the current tap as base, clear the pass map, clear fail and enter SETTLE with the tap index at 0.
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter COMPARE.
REQ-017 COMPARE SHALL last exactly CMP_CYC cycles and set a sticky mismatch flag in any cycle where sample_in != ref_in.
REQ-018 STEP (one cycle) SHALL write pass_map[tap] = ~mismatch, assert inc_pulse, increment tap mod 16 and the tap index, then enter SETTLE if the index was below 15, else EVAL.
REQ-019 A sweep SHALL issue exactly 16 inc_pulses, SHALL end with tap == base, and SHALL take 16*(SETTLE_CYC+CMP_CYC+1) cycles.
REQ-020 EVAL (one cycle) SHALL find the longest run of consecutive 1s in pass_map over indices 0..15 without wrap, breaking ties by lowest start index.
REQ-021 The selected tap SHALL be best_tap = lo + (len-1)/2 using floor division.
REQ-022 With no passing tap, EVAL SHALL set fail=1, keep best_tap at its previous value and go to FIN with tap == base.
REQ-023 SEEK SHALL alternate a pulse cycle with a gap cycle until tap == best_tap; this takes (best_tap - base) mod 16 pulses, and zero pulses means immediate FIN.
REQ-024 FIN SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-025 inc_pulse SHALL never be high outside STEP and SEEK pulse cycles, and never high for two consecutive cycles in SEEK.
REQ-026 start while busy SHALL be ignored with no effect on state or outputs.

Reset
REQ-027 rst SHALL force IDLE, tap=0, inc_pulse=0, busy=0, done=0, fail=0, best_tap=0 and pass_map=0 at the next edge, including mid-sweep.
REQ-028 The var_delay15 instance SHALL share rst so that both sides restart at tap 0.

Configuration
REQ-029 DELAY_CAL_STATUS_EN defined: the block SHALL add output pass_map_o[15:0], the last completed sweep's pass map, reset 0 and updated in EVAL.
REQ-030 DELAY_CAL_STATUS_EN undefined: the port SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package delay_cal_pkg SHALL hold TAP_W=4, NUM_TAPS=16 and the state enum type.
REQ-032 Sub-module delay_cal_win_eval SHALL take a 16-bit map and return lo, len, best_tap and none; it is purely combinational and used in EVAL.

Verification
REQ-033 All taps pass (ref_in tied to sample_in), start from tap 0 -> 16 sweep pulses, best_tap=7, 7 SEEK pulses, tap=7, fail=0, done after 592+1+13+1 cycles (±1).
REQ-034 Passing taps 3..9 only (bench forces mismatch elsewhere) -> best_tap=6, tap=6.
REQ-035 Passing windows 1..3 and 8..12 -> best_tap=10; windows 2..4 and 9..11 (tie) -> best_tap=3.
REQ-036 No passing tap, start at base 5 -> fail=1, best_tap unchanged, tap=5, exactly 16 pulses, done pulse.
REQ-037 rst asserted in cycle 100 of a sweep -> next cycle tap=0, busy=0, inc_pulse=0; a fresh start completes normally.
REQ-038 start re-asserted every cycle during a sweep -> pulse count and timing identical to a single start; tap mirrors an independent var_delay15 model at every cycle.
